note_input_encoder: RTL

//  Upstream front end of the synth voice path. Debounces 12 raw piano-key switches and octave up/down buttons.

---
 rtl/note_input_encoder_pkg.sv | 23 ++
 rtl/input_debouncer.sv | 45 ++++
 rtl/note_input_encoder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/note_input_encoder_pkg.sv
// Shared types for the note input front end:
// note codes, octave limits, field widths and FSM states.
package note_input_encoder_pkg;

  localparam int NOTE_W = 4;
  localparam int OCT_W  = 3;

  localparam logic [OCT_W-1:0] OCT_MIN = OCT_W'(0);
  localparam logic [OCT_W-1:0] OCT_MAX = OCT_W'(7);

  typedef enum logic [NOTE_W-1:0] {
    NOTE_C, NOTE_CS, NOTE_D, NOTE_DS,
    NOTE_E, NOTE_F, NOTE_FS, NOTE_G,
    NOTE_GS, NOTE_A, NOTE_AS, NOTE_B
  } note_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/input_debouncer.sv
// One-bit 2-FF synchronizer plus stability counter.
// Emits the debounced level and a one-cycle rising-edge pulse.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        rise  <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_input_encoder.sv
// Key/octave front end: debounces inputs, picks the active note
// (last-pressed priority) and strobes note/octave to the voice path.
module note_input_encoder
  import note_input_encoder_pkg::*;
#(
  parameter int NUM_KEYS        = 12,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int OCTAVE_RESET    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                oct_up,
  input  logic                oct_down,
  output logic [NOTE_W-1:0]   note,
  output logic [OCT_W-1:0]    octave,
  output logic                note_in,
  output logic                note_held
);

  localparam int NIN = NUM_KEYS + 2;

  logic [NIN-1:0] raw_all;
  logic [NIN-1:0] lvl_all;
  logic [NIN-1:0] rise_all;

  assign raw_all = {oct_down, oct_up, keys};

  for (genvar i = 0; i < NIN; i++) begin : g_deb
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_all[i]),
      .level(lvl_all[i]),
      .rise (rise_all[i])
    );
  end

  logic [NUM_KEYS-1:0] key_lvl;
  logic [NUM_KEYS-1:0] key_rise;
  logic                up_rise;
  logic                dn_rise;

  assign key_lvl  = lvl_all[NUM_KEYS-1:0];
  assign key_rise = rise_all[NUM_KEYS-1:0];
  assign up_rise  = rise_all[NUM_KEYS];
  assign dn_rise  = rise_all[NUM_KEYS+1];

  state_t            state;
  state_t            state_nx;
  logic [NOTE_W-1:0] last_key;
  logic [NOTE_W-1:0] last_nx;
  logic [NOTE_W-1:0] rise_idx;
  logic [NOTE_W-1:0] held_idx;
  logic [NOTE_W-1:0] target;
  logic              last_held;
  logic              any_held;
  logic [OCT_W-1:0]  oct_q;

  assign any_held = |key_lvl;
  assign note_in  = (state == S_LOAD);

  // Fresh presses update last_key before the target is chosen.
  always_comb begin
    rise_idx  = '0;
    held_idx  = '0;
    last_held = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_rise[i]) rise_idx = NOTE_W'(i);
      if (key_lvl[i])  held_idx = NOTE_W'(i);
    end
    last_nx = (|key_rise) ? rise_idx : last_key;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (NOTE_W'(i) == last_nx) last_held = key_lvl[i];
    end
    target = last_held ? last_nx : held_idx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (any_held) state_nx = S_LOAD;
      S_LOAD: state_nx = S_HOLD;
      S_HOLD: begin
        if (!any_held)
          state_nx = S_IDLE;
        else if ({target, oct_q} != {note, octave})
          state_nx = S_LOAD;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      last_key  <= NOTE_C;
      oct_q     <= OCT_W'(OCTAVE_RESET);
      note      <= NOTE_C;
      octave    <= OCT_W'(OCTAVE_RESET);
      note_held <= 1'b0;
    end else begin
      state     <= state_nx;
      last_key  <= last_nx;
      note_held <= any_held;
      unique case (1'b1)
        up_rise && !dn_rise:
          if (oct_q != OCT_MAX) oct_q <= oct_q + 1'b1;
        dn_rise && !up_rise:
          if (oct_q != OCT_MIN) oct_q <= oct_q - 1'b1;
        default: ;
      endcase
      if (state_nx == S_LOAD) begin
        note   <= target;
        octave <= oct_q;
      end
    end
  end

endmodule
